// File: rtl/fifo_bist.sv
// fifo_bist: single-clock FIFO self-test engine with an LFSR traffic generator and a scoreboard.
// Define FIFO_BIST_FLAG_CHECK_EN to also check full/empty against tracked occupancy in mode 0.
module fifo_bist #(
  parameter int          DWIDTH = 8,
  parameter int          DEPTH  = 16,
  parameter int          NWORDS = 64,
  parameter int          CNTW   = 16,
  parameter int          RDLAT  = 1,
  parameter logic [31:0] SEED   = 32'h1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              push,
  output logic [DWIDTH-1:0] wdata,
  input  logic              full,
  output logic              pop,
  input  logic [DWIDTH-1:0] rdata,
  input  logic              empty,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNTW-1:0]   err_count,
  output logic [CNTW-1:0]   wr_count,
  output logic [CNTW-1:0]   rd_count
);

  localparam logic [31:0]     SEED_EFF   = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0]     THR_SEED   = (~SEED_EFF == 32'h0) ? 32'h1 : ~SEED_EFF;
  localparam logic [CNTW-1:0] NW         = CNTW'(NWORDS);
  localparam logic [2:0]      FLUSH_LAST = 3'((RDLAT == 0) ? 0 : RDLAT - 1);

  typedef enum logic [2:0] {IDLE, FILL, DRAIN, STREAM, FLUSH, DONE} state_t;

  state_t          state_q;
  logic [1:0]      mode_q;
  logic [31:0]     wrLfsr_q, expLfsr_q, thrLfsr_q;
  logic [CNTW-1:0] wrCnt_q, rdCnt_q, rdIss_q, errCnt_q;
  logic [2:0]      flushCnt_q;
  logic            busy_q, done_q, pass_q;

  logic            wrAcc, rdAcc, cmpValid, mismatch, flagErr, throttle;
  logic [CNTW-1:0] wrNext, rdIssNext, errNext;
  logic [1:0]      errInc;
  logic [CNTW:0]   errSum;

  function automatic logic [31:0] lfsrNext(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  // Strobes are combinational so a flag change is honoured in the same cycle.
  assign throttle = (mode_q == 2'd2);
  assign push = (state_q == FILL || state_q == STREAM) && !full && (wrCnt_q < NW) &&
                (!throttle || thrLfsr_q[0]);
  assign pop  = (state_q == DRAIN || state_q == STREAM) && !empty && (rdIss_q < NW) &&
                (!throttle || thrLfsr_q[1]);
  assign wdata = push ? wrLfsr_q[DWIDTH-1:0] : '0;
  assign wrAcc = push;
  assign rdAcc = pop;

  generate
    if (RDLAT == 0) begin : gNoLat
      assign cmpValid = rdAcc;
    end else begin : gLat
      logic [RDLAT-1:0] vld_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) vld_q <= '0;
        else       vld_q <= RDLAT'({vld_q, rdAcc});
      end
      assign cmpValid = vld_q[RDLAT-1];
    end
  endgenerate

  assign mismatch  = cmpValid && (rdata != expLfsr_q[DWIDTH-1:0]);
  assign wrNext    = wrCnt_q + CNTW'(wrAcc);
  assign rdIssNext = rdIss_q + CNTW'(rdAcc);

`ifdef FIFO_BIST_FLAG_CHECK_EN
  localparam int OCCW = $clog2(DEPTH + 1) + 1;
  logic [OCCW-1:0] occ_q, occNext;
  assign occNext = occ_q + OCCW'(wrAcc) - OCCW'(rdAcc);
  assign flagErr = (state_q == FILL || state_q == DRAIN) &&
                   ((full != (occ_q == OCCW'(DEPTH))) || (empty != (occ_q == '0)));
`else
  assign flagErr = 1'b0;
`endif

  // A data mismatch and a flag error can land in the same cycle, so the sum saturates.
  assign errInc  = {1'b0, mismatch} + {1'b0, flagErr};
  assign errSum  = {1'b0, errCnt_q} + (CNTW+1)'(errInc);
  assign errNext = errSum[CNTW] ? '1 : errSum[CNTW-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      mode_q     <= 2'd0;
      wrLfsr_q   <= SEED_EFF;
      expLfsr_q  <= SEED_EFF;
      thrLfsr_q  <= THR_SEED;
      wrCnt_q    <= '0;
      rdCnt_q    <= '0;
      rdIss_q    <= '0;
      errCnt_q   <= '0;
      flushCnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
`ifdef FIFO_BIST_FLAG_CHECK_EN
      occ_q      <= '0;
`endif
    end else begin
      thrLfsr_q <= lfsrNext(thrLfsr_q);
      if (wrAcc) begin
        wrLfsr_q <= lfsrNext(wrLfsr_q);
        wrCnt_q  <= wrNext;
      end
      if (rdAcc) rdIss_q <= rdIssNext;
      if (cmpValid) begin
        expLfsr_q <= lfsrNext(expLfsr_q);
        rdCnt_q   <= rdCnt_q + CNTW'(1);
      end
      errCnt_q <= errNext;
`ifdef FIFO_BIST_FLAG_CHECK_EN
      occ_q <= occNext;
`endif
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q    <= (mode == 2'd0) ? FILL : STREAM;
            mode_q     <= mode;
            wrLfsr_q   <= SEED_EFF;
            expLfsr_q  <= SEED_EFF;
            wrCnt_q    <= '0;
            rdCnt_q    <= '0;
            rdIss_q    <= '0;
            errCnt_q   <= '0;
            flushCnt_q <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
`ifdef FIFO_BIST_FLAG_CHECK_EN
            occ_q      <= '0;
`endif
          end
        end
        FILL:   if (full || wrNext == NW) state_q <= DRAIN;
        DRAIN: begin
          if (rdIssNext == NW)             state_q <= FLUSH;
          else if (empty && wrCnt_q < NW) state_q <= FILL;
        end
        STREAM: if (rdIssNext == NW) state_q <= FLUSH;
        FLUSH: begin
          // The last compare happens in the final FLUSH cycle and is folded into pass.
          if (flushCnt_q == FLUSH_LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (errNext == '0);
          end else begin
            flushCnt_q <= flushCnt_q + 3'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = errCnt_q;
  assign wr_count  = wrCnt_q;
  assign rd_count  = rdCnt_q;

endmodule

// File: tb/tb_fifo_bist.sv
// tb_fifo_bist: drives fifo_bist against a queue-style FIFO model and checks data, flags and counts.
// Honours FIFO_BIST_FLAG_CHECK_EN for the expected outcome of the early-full run.
module tb_fifo_bist;
  localparam int          DW    = 8;
  localparam int          DEPTH = 16;
  localparam int          NW    = 64;
  localparam int          CNTW  = 16;
  localparam int          RDLAT = 1;
  localparam logic [31:0] SEED  = 32'hACE1;

  logic            clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [1:0]      mode = 2'd0;
  logic            push, pop, full, empty, busy, done, pass;
  logic [DW-1:0]   wdata, rdata;
  logic [CNTW-1:0] err_count, wr_count, rd_count;

  int vectors = 0, miscompares = 0, cyc = 0;

  int  fullLevel = DEPTH, corruptIdx = -1, corruptBit = 0, runMode = 0;
  bit  alwaysReady = 0, stallEn = 0, stallNow = 0;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] expWords [NW];
  logic [DW-1:0] rdataR;
  int  wrPtr, rdPtr, fifoCount, pushIdx, popIdx;

  fifo_bist #(.DWIDTH(DW), .DEPTH(DEPTH), .NWORDS(NW), .CNTW(CNTW), .RDLAT(RDLAT), .SEED(SEED)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .push(push), .wdata(wdata), .full(full),
    .pop(pop), .rdata(rdata), .empty(empty),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .wr_count(wr_count), .rd_count(rd_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Polynomial x^32+x^22+x^2+x+1 as a parity over the tapped bits.
  function automatic logic [31:0] stepLfsr(input logic [31:0] s);
    return {s[30:0], ^(s & 32'h8020_0003)};
  endfunction

  function automatic logic [DW-1:0] corrupt(input int idx, input logic [DW-1:0] w);
    logic [DW-1:0] r;
    r = w;
    if (idx == corruptIdx) r[corruptBit] = ~r[corruptBit];
    return r;
  endfunction

  assign full  = !alwaysReady && (fifoCount >= fullLevel);
  assign empty = stallNow || (!alwaysReady && fifoCount == 0);
  assign rdata = rdataR;

  // FIFO model: ideal ring buffer with one cycle of read latency, or a source that never runs dry.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= 0; rdPtr <= 0; fifoCount <= 0; pushIdx <= 0; popIdx <= 0; rdataR <= '0;
    end else if (start && !busy) begin
      pushIdx <= 0; popIdx <= 0;
    end else begin
      if (push && !full) begin
        if (!alwaysReady) begin
          mem[wrPtr] <= corrupt(pushIdx, wdata);
          wrPtr      <= (wrPtr + 1) % DEPTH;
        end
        pushIdx <= pushIdx + 1;
      end
      if (pop && !empty) begin
        if (alwaysReady) rdataR <= corrupt(popIdx, expWords[popIdx % NW]);
        else begin
          rdataR <= mem[rdPtr];
          rdPtr  <= (rdPtr + 1) % DEPTH;
        end
        popIdx <= popIdx + 1;
      end
      if (!alwaysReady) fifoCount <= fifoCount + int'(push && !full) - int'(pop && !empty);
    end
  end

  always @(posedge clk) begin
    #1 stallNow = stallEn && ($urandom_range(0, 3) == 0);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Per-cycle protocol and write-data checks while a run is active.
  always @(negedge clk) begin
    if (!reset && busy) begin
      if (push)                 checkOutput("wdata", 32'(wdata), 32'(expWords[pushIdx % NW]));
      if (full)                 checkOutput("pushWhileFull", 32'(push), 0);
      if (empty)                checkOutput("popWhileEmpty", 32'(pop), 0);
      if (runMode == 0 && push) checkOutput("fillDrainOverlap", 32'(pop), 0);
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".push"}, 32'(push), 0);
    checkOutput({tag, ".pop"}, 32'(pop), 0);
    checkOutput({tag, ".wdata"}, 32'(wdata), 0);
    checkOutput({tag, ".busy"}, 32'(busy), 0);
    checkOutput({tag, ".done"}, 32'(done), 0);
    checkOutput({tag, ".pass"}, 32'(pass), 0);
    checkOutput({tag, ".err"}, 32'(err_count), 0);
    checkOutput({tag, ".wr"}, 32'(wr_count), 0);
    checkOutput({tag, ".rd"}, 32'(rd_count), 0);
  endtask

  task automatic applyStimulus(input logic [1:0] m, input bit ready, input bit stall, input int fl,
                               input int cIdx, input int cBit, input bit extraStart, output int cycles);
    int startCyc, waited;
    @(negedge clk);
    runMode = (m == 2'd0) ? 0 : 1;
    alwaysReady = ready; stallEn = stall; fullLevel = fl; corruptIdx = cIdx; corruptBit = cBit;
    mode = m; start = 1'b1; startCyc = cyc;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (!done && waited < 4000) begin
      @(negedge clk);
      waited++;
      if (extraStart && waited == 10) begin mode = 2'd0; start = 1'b1; end
      else start = 1'b0;
    end
    start = 1'b0;
    cycles = cyc - startCyc;
    stallEn = 0;
  endtask

  // expErr < 0 means "at least one error".
  task automatic checkRun(input string tag, input int expErr);
    checkOutput({tag, ".done"}, 32'(done), 1);
    checkOutput({tag, ".busy"}, 32'(busy), 0);
    checkOutput({tag, ".wrCount"}, 32'(wr_count), NW);
    checkOutput({tag, ".rdCount"}, 32'(rd_count), NW);
    checkOutput({tag, ".pushes"}, 32'(pushIdx), NW);
    checkOutput({tag, ".pops"}, 32'(popIdx), NW);
    if (expErr < 0) checkOutput({tag, ".errSeen"}, 32'(err_count != 0), 1);
    else            checkOutput({tag, ".err"}, 32'(err_count), 32'(expErr));
    checkOutput({tag, ".pass"}, 32'(pass), (expErr == 0) ? 1 : 0);
    repeat (3) @(negedge clk);
    checkOutput({tag, ".doneHeld"}, 32'(done), 1);
  endtask

  initial begin
    logic [31:0] s;
    int cycles, expFlagRun;
    s = SEED;
    for (int i = 0; i < NW; i++) begin
      expWords[i] = s[DW-1:0];
      s = stepLfsr(s);
    end

    repeat (3) @(negedge clk);
    checkResetValues("inReset");
    reset = 1'b0;
    @(negedge clk);
    checkResetValues("idle");

    applyStimulus(2'd0, 0, 0, DEPTH, -1, 0, 0, cycles);
    checkRun("fillDrain", 0);

    applyStimulus(2'd1, 1, 0, DEPTH, -1, 0, 0, cycles);
    checkRun("streamReady", 0);
    checkOutput("streamLatency", 32'(cycles <= NW + RDLAT + 2), 1);

    applyStimulus(2'd2, 0, 1, DEPTH, -1, 0, 0, cycles);
    checkRun("throttled", 0);

    applyStimulus(2'd0, 0, 0, DEPTH, 5, 0, 0, cycles);
    checkRun("corruptWord5", 1);

    for (int r = 0; r < 3; r++) begin
      applyStimulus(2'($urandom_range(1, 3)), 0, 1, DEPTH, $urandom_range(0, NW - 1),
                    $urandom_range(0, DW - 1), 1, cycles);
      checkRun("randomCorrupt", 1);
    end

    // Abort a streaming run with reset, then confirm a clean rerun.
    @(negedge clk);
    runMode = 1; alwaysReady = 0; stallEn = 1; fullLevel = DEPTH; corruptIdx = -1;
    mode = 2'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    #1;
    checkResetValues("midReset");
    @(negedge clk);
    reset = 1'b0;
    stallEn = 0;
    applyStimulus(2'd1, 0, 1, DEPTH, -1, 0, 0, cycles);
    checkRun("afterReset", 0);

`ifdef FIFO_BIST_FLAG_CHECK_EN
    expFlagRun = -1;
`else
    expFlagRun = 0;
`endif
    applyStimulus(2'd0, 0, 0, DEPTH - 1, -1, 0, 0, cycles);
    checkRun("earlyFull", expFlagRun);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
